reg_port_sequencer: RTL and testbench
=====================================

REG_PORT_SEQUENCER -- requirements
Module: reg_port_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register width and number of shift cycles per pass.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe, accepted only when ready=1.
- rd_req  in  1  read rs1/rs2 this transaction.
- wr_req  in  1  write wdata to rd this transaction.
- rs1, rs2  in  4  source register indices.
- rd  in  4  destination register index.
- wdata  in  WIDTH  parallel write data.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- rdata1, rdata2  out  WIDTH  parallel read results.
- r_sel1, r_sel2  out  4  register-file read selects.
- write_register  out  4  register-file write select.
- write_value  out  1  serial write bit.
- wr_en  out  1  register-file write enable.
- shift  out  1  register-file rotate enable.
- r_value1, r_value2  in  1  serial read bits, MSB-first.

Function
REQ-003 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-004 In IDLE, on start=1, SHALL latch rd_req, wr_req, rs1, rs2, rd and wdata.
- Next state: READ if rd_req=1.
- Else WRITE if wr_req=1 and rd!=0.
- Else DONE.
REQ-005 start SHALL be ignored in every state other than IDLE.
REQ-006 READ SHALL last exactly WIDTH cycles with shift=1 and wr_en=0.
REQ-007 In READ cycle k (k=0..WIDTH-1), rdata1 and rdata2 SHALL shift left by one, taking r_value1 and r_value2 into bit 0. After WIDTH cycles, rdataN[WIDTH-1-k] therefore holds the bit sampled in cycle k.
REQ-008 After the last READ cycle, SHALL go to WRITE if the latched wr_req=1 and rd!=0, else to DONE.
REQ-009 WRITE SHALL last exactly WIDTH cycles with shift=1 and wr_en=1.
REQ-010 In WRITE cycle k, write_value SHALL equal wdata[(WIDTH-k) mod WIDTH]: wdata[0] in cycle 0, wdata[WIDTH-1] in cycle 1, down to wdata[1] in cycle WIDTH-1.
REQ-011 A write to rd=0 SHALL skip WRITE entirely; wr_en SHALL never assert with write_register=0.
REQ-012 DONE SHALL last one cycle with done=1, shift=0 and wr_en=0, then return to IDLE.
REQ-013 Latency from the start-accept edge to done: WIDTH+1 cycles read-only, WIDTH+1 write-only, 2*WIDTH+1 read+write, 1 for neither.
REQ-014 shift SHALL be high only in READ and WRITE, with no gap cycle between READ and WRITE.
REQ-015 wr_en SHALL be high only in WRITE; write_value SHALL be 0 outside WRITE.
REQ-016 r_sel1, r_sel2 and write_register SHALL hold the latched indices from accept until the next accepted start.
REQ-017 rdata1 and rdata2 SHALL change only in READ, and hold their value from DONE until the next READ.
REQ-018 A transaction without rd_req SHALL leave rdata1 and rdata2 unchanged.
REQ-019 When rs1=rs2, rdata1 SHALL equal rdata2.
REQ-020 Read-before-write ordering SHALL guarantee rdata reflects pre-write contents when rd equals rs1 or rs2.
REQ-021 The phase counter SHALL be log2(WIDTH) bits, wrap 0..WIDTH-1, and clear on every phase entry.

Reset
REQ-022 While rst=1, asynchronously:
- state=IDLE, counter=0, ready=1.
- done=0, shift=0, wr_en=0, write_value=0.
- rdata1, rdata2, r_sel1, r_sel2, write_register all 0.
REQ-023 Reset asserted mid-READ or mid-WRITE SHALL abort immediately with no further shift pulses. rst SHALL be driven together with the register-file reset, since a partial rotation leaves register contents misaligned.
REQ-024 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (bench uses a rotating register-file model: rotate-left on shift, MSB out, write to bit 1)
REQ-025 Write-only: wr_req=1, rd=5, wdata=0xDEADBEEF.
- Response: done exactly 33 cycles after accept; wr_en high for 32 cycles.
- Then a read of rs1=5 returns rdata1=0xDEADBEEF.
REQ-026 Read+write, rs1=rd=3 preloaded with 0x12345678, wdata=0xCAFEF00D.
- Response: rdata1=0x12345678, done at cycle 65.
- Then a read returns 0xCAFEF00D.
REQ-027 Write to rd=0 with rd_req=0: done at cycle 1, shift and wr_en never assert, x0 stays 0.
REQ-028 rs1=7 (0x80000001), rs2=9 (0x7FFFFFFE), read only.
- Response: rdata1=0x80000001 and rdata2=0x7FFFFFFE after 33 cycles.
- All register contents are unchanged after the 32 rotations.
REQ-029 Reset pulse at READ cycle 10: shift drops in the same cycle, ready=1, all outputs 0.
- A start 1 cycle after release is accepted.
REQ-030 start held high during an active transaction: no second accept until ready=1, then exactly one new transaction.

Source files
------------

// File: rtl/reg_port_sequencer_if.sv
// Request/response bus between a transaction issuer and reg_port_sequencer.
// The issuer drives the request fields and start; the sequencer returns ready, done and read data.
interface reg_port_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             rd_req;
    logic             wr_req;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rd;
    logic [WIDTH-1:0] wdata;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;

    modport master (
        output start, rd_req, wr_req, rs1, rs2, rd, wdata,
        input  ready, done, rdata1, rdata2
    );

    modport slave (
        input  start, rd_req, wr_req, rs1, rs2, rd, wdata,
        output ready, done, rdata1, rdata2
    );
endinterface

// File: rtl/reg_port_sequencer.sv
// Sequences one read and/or write pass over a bit-serial rotating register file.
// Reads gather MSB-first into parallel results; writes stream wdata so it lands aligned after WIDTH rotations.
module reg_port_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_port_sequencer_if.slave  bus,
    output logic [3:0]           r_sel1,
    output logic [3:0]           r_sel2,
    output logic [3:0]           write_register,
    output logic                 write_value,
    output logic                 wr_en,
    output logic                 shift,
    input  logic                 r_value1,
    input  logic                 r_value2
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             accept_s;
    logic             wr_req_r;
    logic [3:0]       r_sel1_r, r_sel2_r, write_register_r;
    logic [WIDTH-1:0] wdata_r, rdata1_r, rdata2_r;
    logic [WIDTH-1:0] wsrc_s;
    logic [CW-1:0]    widx_s;
    logic             wv_s;
    logic             ready_r, done_r, shift_r, wr_en_r, wv_r;

    // Next-state and phase-counter logic; the counter restarts at zero on every phase entry.
    always_comb begin
        state_s  = state_r;
        cnt_s    = CNT_ZERO;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    if (bus.rd_req) begin
                        state_s = READ;
                    end else if (bus.wr_req && (bus.rd != 4'd0)) begin
                        state_s = WRITE;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                if (cnt_r == CNT_LAST) begin
                    if (wr_req_r && (write_register_r != 4'd0)) begin
                        state_s = WRITE;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = READ;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            WRITE: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Write bit for the upcoming cycle: wdata[(WIDTH-k) mod WIDTH] lands at its final position after the rotations.
    always_comb begin
        if (state_r == IDLE) begin
            wsrc_s = bus.wdata;
        end else begin
            wsrc_s = wdata_r;
        end
        widx_s = CNT_ZERO - cnt_s;
        if (state_s == WRITE) begin
            wv_s = wsrc_s[widx_s];
        end else begin
            wv_s = 1'b0;
        end
    end

    // State and phase counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Control strobes registered from the next state so they align exactly with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            shift_r <= 1'b0;
            wr_en_r <= 1'b0;
            wv_r    <= 1'b0;
        end else begin
            ready_r <= (state_s == IDLE);
            done_r  <= (state_s == DONE);
            shift_r <= (state_s == READ) || (state_s == WRITE);
            wr_en_r <= (state_s == WRITE);
            wv_r    <= wv_s;
        end
    end

    // Transaction fields captured on accept and held until the next accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_req_r         <= 1'b0;
            r_sel1_r         <= 4'd0;
            r_sel2_r         <= 4'd0;
            write_register_r <= 4'd0;
            wdata_r          <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            wr_req_r         <= bus.wr_req;
            r_sel1_r         <= bus.rs1;
            r_sel2_r         <= bus.rs2;
            write_register_r <= bus.rd;
            wdata_r          <= bus.wdata;
        end
    end

    // Read results shift in MSB-first and only move during READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1_r <= {WIDTH{1'b0}};
            rdata2_r <= {WIDTH{1'b0}};
        end else if (state_r == READ) begin
            rdata1_r <= {rdata1_r[WIDTH-2:0], r_value1};
            rdata2_r <= {rdata2_r[WIDTH-2:0], r_value2};
        end
    end

    assign bus.ready      = ready_r;
    assign bus.done       = done_r;
    assign bus.rdata1     = rdata1_r;
    assign bus.rdata2     = rdata2_r;
    assign r_sel1         = r_sel1_r;
    assign r_sel2         = r_sel2_r;
    assign write_register = write_register_r;
    assign write_value    = wv_r;
    assign wr_en          = wr_en_r;
    assign shift          = shift_r;
endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed bench for reg_port_sequencer against a 16-entry rotating register-file model
// (rotate-left on shift, MSB read out, write bit inserted at bit 1).
module tb_reg_port_sequencer;
    localparam int W = 32;

    typedef struct {
        logic        rd_req;
        logic        wr_req;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [31:0] wdata;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        int          e_lat;
        int          e_shift;
        int          e_wr;
    } vec_t;

    logic clk;
    logic rst;
    logic [3:0] r_sel1, r_sel2, write_register;
    logic write_value, wr_en, shift;
    logic r_value1, r_value2;
    logic [31:0] regs [16];

    int n_checks;
    int n_errors;

    reg_port_sequencer_if #(.WIDTH(W)) bus ();

    reg_port_sequencer #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .r_sel1         (r_sel1),
        .r_sel2         (r_sel2),
        .write_register (write_register),
        .write_value    (write_value),
        .wr_en          (wr_en),
        .shift          (shift),
        .r_value1       (r_value1),
        .r_value2       (r_value2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rf_step(input logic [31:0] v, input logic we, input logic b);
        logic [31:0] t;
        t = {v[30:0], v[31]};
        if (we) t[1] = b;
        return t;
    endfunction

    // Register-file model, reset together with the sequencer.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
        end else if (shift) begin
            for (int i = 0; i < 16; i++)
                regs[i] <= rf_step(regs[i], wr_en && (write_register == 4'(i)), write_value);
        end
    end

    assign r_value1 = regs[r_sel1][31];
    assign r_value2 = regs[r_sel2][31];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        bus.start  = 1'b1;
        bus.rd_req = v.rd_req;
        bus.wr_req = v.wr_req;
        bus.rs1    = v.rs1;
        bus.rs2    = v.rs2;
        bus.rd     = v.rd;
        bus.wdata  = v.wdata;
    endtask

    // Waits for the accept edge, then follows the transaction to done, sampling on negedges.
    task automatic track(input vec_t v, input string tag);
        int lat, shifts, wrs, viol;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1; shifts = 0; wrs = 0; viol = 0;
        while (!bus.done && lat < 200) begin
            if (shift) shifts++;
            if (wr_en) wrs++;
            if (wr_en && write_register == 4'd0) viol++;
            if (!wr_en && write_value) viol++;
            if (wr_en && !shift) viol++;
            if (bus.ready) viol++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (shift || wr_en || write_value) viol++;
        check({tag, " latency"}, 64'(lat), 64'(v.e_lat));
        check({tag, " shift cycles"}, 64'(shifts), 64'(v.e_shift));
        check({tag, " wr_en cycles"}, 64'(wrs), 64'(v.e_wr));
        check({tag, " rdata1"}, 64'(bus.rdata1), 64'(v.e_rd1));
        check({tag, " rdata2"}, 64'(bus.rdata2), 64'(v.e_rd2));
        check({tag, " selects"}, 64'({r_sel1, r_sel2, write_register}), 64'({v.rs1, v.rs2, v.rd}));
        check({tag, " protocol"}, 64'(viol), 64'd0);
        @(negedge clk);
        check({tag, " back to idle"}, 64'({bus.ready, bus.done, shift}), 64'(3'b100));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        @(negedge clk);
        issue(v);
        track(v, tag);
    endtask

    vec_t vt [12];
    vec_t v;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        bus.rs1 = 4'd0; bus.rs2 = 4'd0; bus.rd = 4'd0; bus.wdata = 32'd0;

        //                rd wr rs1    rs2    rd     wdata          e_rd1          e_rd2         lat sh  wr
        vt[0]  = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd5, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 33, 32, 32};
        vt[1]  = '{1'b1, 1'b0, 4'd5, 4'd0, 4'd0, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 33, 32, 0};
        vt[2]  = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 32'h12345678, 32'hDEADBEEF, 32'h00000000, 33, 32, 32};
        vt[3]  = '{1'b1, 1'b1, 4'd3, 4'd3, 4'd3, 32'hCAFEF00D, 32'h12345678, 32'h12345678, 65, 64, 32};
        vt[4]  = '{1'b1, 1'b0, 4'd3, 4'd5, 4'd0, 32'h00000000, 32'hCAFEF00D, 32'hDEADBEEF, 33, 32, 0};
        vt[5]  = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 32'hFFFFFFFF, 32'hCAFEF00D, 32'hDEADBEEF, 1, 0, 0};
        vt[6]  = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 32'h80000001, 32'hCAFEF00D, 32'hDEADBEEF, 33, 32, 32};
        vt[7]  = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 32'h7FFFFFFE, 32'hCAFEF00D, 32'hDEADBEEF, 33, 32, 32};
        vt[8]  = '{1'b1, 1'b0, 4'd7, 4'd9, 4'd0, 32'h00000000, 32'h80000001, 32'h7FFFFFFE, 33, 32, 0};
        vt[9]  = '{1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 32'h00000000, 32'h00000000, 32'h80000001, 33, 32, 0};
        vt[10] = '{1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h00000000, 32'h00000000, 32'h80000001, 1, 0, 0};
        vt[11] = '{1'b1, 1'b1, 4'd9, 4'd3, 4'd0, 32'h12345678, 32'h7FFFFFFE, 32'hCAFEF00D, 33, 32, 0};

        // Reset state.
        #3;
        check("reset ready", 64'(bus.ready), 64'd1);
        check("reset strobes", 64'({bus.done, shift, wr_en, write_value}), 64'd0);
        check("reset rdata", 64'({bus.rdata1, bus.rdata2}), 64'd0);
        check("reset selects", 64'({r_sel1, r_sel2, write_register}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        // Register contents after all passes, including full-rotation reads.
        check("x0 contents", 64'(regs[0]), 64'h0);
        check("x3 contents", 64'(regs[3]), 64'hCAFEF00D);
        check("x5 contents", 64'(regs[5]), 64'hDEADBEEF);
        check("x7 contents", 64'(regs[7]), 64'h80000001);
        check("x9 contents", 64'(regs[9]), 64'h7FFFFFFE);

        // start held high through a transaction: exactly one re-accept once back in IDLE.
        v = '{1'b1, 1'b0, 4'd5, 4'd7, 4'd0, 32'h0, 32'hDEADBEEF, 32'h80000001, 33, 32, 0};
        @(negedge clk);
        issue(v);
        begin
            int lat, acc_seen;
            @(posedge clk);
            @(negedge clk);
            lat = 1; acc_seen = 0;
            while (!bus.done && lat < 200) begin
                if (bus.ready) acc_seen++;
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            check("held start latency", 64'(lat), 64'd33);
            check("held start no early idle", 64'(acc_seen), 64'd0);
            @(negedge clk);
            check("held start idle", 64'(bus.ready), 64'd1);
        end
        track(v, "held start second");
        repeat (4) begin
            @(negedge clk);
            check("held start single re-accept", 64'({bus.ready, shift}), 64'(2'b10));
        end

        // Reset pulse at READ cycle 10.
        v = '{1'b1, 1'b0, 4'd7, 4'd9, 4'd0, 32'h0, 32'h0, 32'h0, 33, 32, 0};
        @(negedge clk);
        issue(v);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("read cycle 10 shifting", 64'(shift), 64'd1);
        rst = 1'b1;
        #1;
        check("abort shift", 64'(shift), 64'd0);
        check("abort ready", 64'(bus.ready), 64'd1);
        check("abort outputs", 64'({bus.done, wr_en, write_value, r_sel1, r_sel2, write_register}), 64'd0);
        check("abort rdata", 64'({bus.rdata1, bus.rdata2}), 64'd0);
        @(negedge clk);
        check("abort no shift under reset", 64'(shift), 64'd0);
        rst = 1'b0;
        v = '{1'b0, 1'b1, 4'd0, 4'd0, 4'd4, 32'hA5A50F0F, 32'h0, 32'h0, 33, 32, 32};
        issue(v);
        track(v, "post-reset write");
        v = '{1'b1, 1'b0, 4'd4, 4'd0, 4'd0, 32'h0, 32'hA5A50F0F, 32'h0, 33, 32, 0};
        run_txn(v, "post-reset read");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
